// File: rtl/prodacc_pkg.sv
// Shared types and constants for the prodacc signed product accumulator.
// Optional clamp-on-overflow behaviour is selected with the PRODACC_SAT_EN macro.
package prodacc_pkg;

    localparam int PW_DEF = 16;
    localparam int AW_DEF = 24;
    localparam int LW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp limits for the default accumulator width.
    localparam logic [AW_DEF-1:0] SAT_POS = {1'b0, {(AW_DEF-1){1'b1}}};
    localparam logic [AW_DEF-1:0] SAT_NEG = {1'b1, {(AW_DEF-1){1'b0}}};

endpackage

// File: rtl/prodacc_if.sv
// Product stream, result stream and status signals of prodacc.
// A transfer happens on a rising edge where valid and ready are both high.
interface prodacc_if #(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int LW = 8
);
    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic [PW-1:0] in_prod;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          ovf;

    modport master (
        output start, len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_data, busy, ovf
    );

    modport slave (
        input  start, len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_data, busy, ovf
    );
endinterface

// File: rtl/prodacc_add.sv
// Combinational signed adder: AW-bit accumulator plus sign-extended PW-bit product.
// With PRODACC_SAT_EN defined the result clamps to the signed AW-bit range on overflow.
module prodacc_add #(
    parameter int PW = 16,
    parameter int AW = 24
) (
    input  logic [AW-1:0] i_acc,
    input  logic [PW-1:0] i_prod,
    output logic [AW-1:0] o_sum,
    output logic          o_ovf
);
    logic [AW:0] w_sum;

    assign w_sum = {i_acc[AW-1], i_acc} + {{(AW+1-PW){i_prod[PW-1]}}, i_prod};
    assign o_ovf = w_sum[AW] ^ w_sum[AW-1];

`ifdef PRODACC_SAT_EN
    localparam logic [AW-1:0] W_SAT_POS = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] W_SAT_NEG = {1'b1, {(AW-1){1'b0}}};

    // Bit AW of the wide sum carries the true sign of the result.
    always_comb begin
        o_sum = w_sum[AW-1:0];
        if (o_ovf) begin
            o_sum = w_sum[AW] ? W_SAT_NEG : W_SAT_POS;
        end
    end
`else
    assign o_sum = w_sum[AW-1:0];
`endif

endmodule

// File: rtl/prodacc.sv
// Signed product accumulator: sums a programmed number of products, then offers the total.
// Build with PRODACC_SAT_EN defined to clamp instead of wrap on overflow.
module prodacc
    import prodacc_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic       clk,
    input  logic       nreset,
    prodacc_if.slave   bus,
    output state_t     o_dbg_state
);
    state_t        r_state;
    state_t        w_next;
    logic [LW-1:0] r_cnt;
    logic [AW-1:0] r_acc;
    logic          r_ovf;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_busy;
    logic          w_beat;
    logic          w_start_ok;
    logic [AW-1:0] w_sum;
    logic          w_add_ovf;

    assign w_beat     = bus.in_valid & w_in_ready;
    assign w_start_ok = bus.start & (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = (bus.len != '0) ? ST_ACC : ST_DONE;
            ST_ACC:  if (w_beat && (r_cnt == LW'(1))) w_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decode the state register only.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    prodacc_add #(
        .PW(PW),
        .AW(AW)
    ) u_add (
        .i_acc  (r_acc),
        .i_prod (bus.in_prod),
        .o_sum  (w_sum),
        .o_ovf  (w_add_ovf)
    );

    // A zero length loads cnt with 0, which never matters since ACC is skipped.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_start_ok) begin
            r_acc <= '0;
            r_cnt <= bus.len;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - LW'(1);
            if (w_add_ovf) r_ovf <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_data  = r_acc;
    assign bus.ovf       = r_ovf;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_prodacc.sv
// Self-checking bench for prodacc against an arithmetic reference model.
// Honours PRODACC_SAT_EN the same way the design does.
module tb_prodacc;
    import prodacc_pkg::*;

    localparam int PW = 16;
    localparam int AW = 24;
    localparam int LW = 9;

    logic   clk;
    logic   nreset;
    state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] exp_q[$];
    bit            exp_ovf_q[$];

    prodacc_if #(.PW(PW), .AW(AW), .LW(LW)) bus();

    prodacc #(.PW(PW), .AW(AW), .LW(LW)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_push(input logic [PW-1:0] p[$]);
        longint acc;
        longint s;
        longint pv;
        longint maxv;
        longint minv;
        bit     ov;
        maxv = (longint'(1) <<< (AW-1)) - 1;
        minv = -(longint'(1) <<< (AW-1));
        acc  = 0;
        ov   = 1'b0;
        for (int i = 0; i < p.size(); i++) begin
            pv = $signed(p[i]);
            s  = acc + pv;
            if (s > maxv || s < minv) begin
                ov = 1'b1;
`ifdef PRODACC_SAT_EN
                acc = (s > maxv) ? maxv : minv;
`else
                acc = (s > maxv) ? s - (longint'(1) <<< AW) : s + (longint'(1) <<< AW);
`endif
            end else begin
                acc = s;
            end
        end
        exp_q.push_back(acc[AW-1:0]);
        exp_ovf_q.push_back(ov);
    endtask

    // ---------------- drivers ----------------
    task automatic start_now(input int n);
        bus.start = 1'b1;
        bus.len   = LW'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = LW'($urandom);
    endtask

    task automatic send_start(input int n);
        @(posedge clk); #1;
        start_now(n);
    endtask

    // in_valid is left high after the last beat to probe the DONE boundary.
    task automatic send_beats(input logic [PW-1:0] p[$], input int gap_max);
        for (int i = 0; i < p.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bus.in_valid = 1'b0;
                bus.in_prod  = PW'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_prod  = p[i];
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL in_ready_beat%0d: got %b want 1", i, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_prod = PW'($urandom);
    endtask

    task automatic get_result(input bit check_lat, input int ready_delay);
        logic [AW-1:0] ed;
        bit            eo;
        int            w;
        ed = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        w  = 0;
        forever begin
            @(negedge clk);
            w++;
            if (bus.out_valid === 1'b1 || w >= 64) break;
        end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL out_valid_wait: got %b after %0d cycles want 1", bus.out_valid, w);
        end
        if (check_lat) begin
            n_checks++;
            if (w != 1) begin
                n_errors++;
                $display("FAIL result_latency: got %0d cycles want 1", w);
            end
        end
        n_checks++;
        if (bus.out_data !== ed) begin
            n_errors++;
            $display("FAIL out_data: got %0d want %0d", $signed(bus.out_data), $signed(ed));
        end
        n_checks++;
        if (bus.ovf !== eo) begin
            n_errors++;
            $display("FAIL ovf: got %b want %b", bus.ovf, eo);
        end
        repeat (ready_delay) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== ed || bus.in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL result_hold: valid=%b data=%0d in_ready=%b want 1/%0d/0",
                         bus.out_valid, $signed(bus.out_data), bus.in_ready, $signed(ed));
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
            dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL idle_%s: busy=%b out_valid=%b in_ready=%b state=%0d want 0/0/0/%0d",
                     tag, bus.busy, bus.out_valid, bus.in_ready, dbg_state, ST_IDLE);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nreset        = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_data !== '0 || bus.ovf !== 1'b0 || bus.busy !== 1'b0 ||
            bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: data=%0d ovf=%b busy=%b in_ready=%b out_valid=%b want all 0",
                     bus.out_data, bus.ovf, bus.busy, bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        nreset = 1'b1;
        check_idle("after_reset");
    endtask

    task automatic test_basic();
        logic [PW-1:0] p[$];
        p.push_back(16'd100);
        p.push_back(-16'sd3);
        p.push_back(16'd7);
        p.push_back(16'd0);
        model_push(p);
        send_start(4);
        send_beats(p, 0);
        get_result(1'b1, 0);
        check_idle("basic");
    endtask

    task automatic test_stalls();
        logic [PW-1:0] p[$];
        for (int i = 0; i < 3; i++) p.push_back(PW'($urandom));
        model_push(p);
        send_start(3);
        send_beats(p, 3);
        get_result(1'b1, 5);
        check_idle("stalls");
    endtask

    task automatic test_len0();
        logic [PW-1:0] p[$];
        model_push(p);
        send_start(0);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== '0) begin
            n_errors++;
            $display("FAIL len0_result: valid=%b data=%0d want 1/0", bus.out_valid, bus.out_data);
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = LW'(5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_checks++;
        if (dbg_state !== ST_DONE) begin
            n_errors++;
            $display("FAIL start_in_done: state=%0d want %0d", dbg_state, ST_DONE);
        end
        get_result(1'b0, 1);
        check_idle("len0");
    endtask

    task automatic test_overflow();
        logic [PW-1:0] p[$];
        for (int i = 0; i < 300; i++) p.push_back(16'sd32767);
        model_push(p);
        send_start(300);
        send_beats(p, 0);
        get_result(1'b1, 0);
        check_idle("overflow");
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] p[$];
        p.push_back(PW'($urandom));
        p.push_back(PW'($urandom));
        send_start(5);
        send_beats(p, 0);
        nreset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== '0 || bus.ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: in_ready=%b busy=%b data=%0d ovf=%b want 0/0/0/0",
                     bus.in_ready, bus.busy, bus.out_data, bus.ovf);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        p.delete();
        p.push_back(-16'sd5);
        model_push(p);
        send_start(1);
        send_beats(p, 0);
        get_result(1'b1, 0);
        check_idle("reset_mid");
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] pa[$];
        logic [PW-1:0] pb[$];
        int na;
        int nb;
        na = $urandom_range(2, 6);
        nb = $urandom_range(1, 6);
        for (int i = 0; i < na; i++) pa.push_back(PW'($urandom));
        for (int i = 0; i < nb; i++) pb.push_back(PW'($urandom));
        model_push(pa);
        model_push(pb);
        send_start(na);
        send_beats(pa, 1);
        get_result(1'b1, 0);
        start_now(nb);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.out_data !== '0 || bus.ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_restart: busy=%b data=%0d ovf=%b want 1/0/0",
                     bus.busy, $signed(bus.out_data), bus.ovf);
        end
        @(posedge clk); #1;
        send_beats(pb, 1);
        get_result(1'b1, 2);
        check_idle("b2b");
    endtask

    task automatic test_random();
        logic [PW-1:0] p[$];
        int n;
        for (int v = 0; v < 8; v++) begin
            p.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) p.push_back(PW'($urandom));
            model_push(p);
            send_start(n);
            send_beats(p, 2);
            get_result(1'b1, $urandom_range(0, 3));
        end
        check_idle("random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_len0();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
